// File: rtl/bpred_pkg.sv
// Shared defaults and snapshot layout for the fetch-stage return-address stack.
// Snapshot is packed MSB->LSB as {tos, count, top}.
`define BPRED_RAS_SNAP_W(ptrw, aw) ((ptrw) + (ptrw) + 1 + (aw))

package bpred_pkg;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_AW    = 32;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

  typedef struct packed {
    logic [RAS_PTR_W-1:0] tos;
    logic [RAS_PTR_W:0]   count;
    logic [RAS_AW-1:0]    top;
  } ras_snap_t;

  function automatic int snap_cnt_lsb(input int aw);
    return aw;
  endfunction

  function automatic int snap_tos_lsb(input int ptrw, input int aw);
    return aw + ptrw + 1;
  endfunction
endpackage

// File: rtl/bpred_ras_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module bpred_ras_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [AW-1:0]    wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [AW-1:0]    rdata
);
  (* ramstyle = "MLAB, no_rw_check" *) logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/bpred_ras_ckpt.sv
// Circular return-address stack with snapshot-based one-cycle misprediction repair.
// Optional event counters when BPRED_RAS_STATS_EN is defined.
module bpred_ras_ckpt
  import bpred_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int AW    = RAS_AW,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int SNAP_W = `BPRED_RAS_SNAP_W(PTR_W, AW)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              push,
  input  logic [AW-1:0]     push_addr,
  input  logic              pop,
  output logic [AW-1:0]     top_addr,
  output logic              top_valid,
  output logic [PTR_W:0]    count,
  output logic [SNAP_W-1:0] snap_out,
  input  logic              restore,
  input  logic [SNAP_W-1:0] snap_in,
`ifdef BPRED_RAS_STATS_EN
  output logic [31:0]       stat_push,
  output logic [31:0]       stat_pop,
  output logic [31:0]       stat_ovf,
  output logic [31:0]       stat_unf,
  output logic [31:0]       stat_restore,
`endif
  output logic              ovf_pulse,
  output logic              unf_pulse
);
  localparam logic [PTR_W-1:0] P_ONE = 1;
  localparam logic [PTR_W:0]   C_ONE = 1;
  localparam logic [PTR_W:0]   FULL  = C_ONE << PTR_W;
  localparam int CNT_LSB = snap_cnt_lsb(AW);
  localparam int TOS_LSB = snap_tos_lsb(PTR_W, AW);

  logic [PTR_W-1:0] tos_q, tos_d, tos_m1, waddr;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, we, do_push, do_pop;
  logic [AW-1:0]    wdata;
  logic [PTR_W-1:0] s_tos;
  logic [PTR_W:0]   s_cnt;
  logic [AW-1:0]    s_top;

  assign s_tos   = snap_in[TOS_LSB +: PTR_W];
  assign s_cnt   = snap_in[CNT_LSB +: PTR_W+1];
  assign s_top   = snap_in[AW-1:0];
  assign tos_m1  = tos_q - P_ONE;
  assign do_push = push & ~stall & ~restore;
  assign do_pop  = pop  & ~stall & ~restore;

  always_comb begin
    tos_d = tos_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    we    = 1'b0;
    waddr = tos_q;
    wdata = push_addr;
    if (restore) begin
      tos_d = s_tos;
      cnt_d = s_cnt;
      we    = (s_cnt != '0);
      waddr = s_tos - P_ONE;
      wdata = s_top;
    end else if (do_push && do_pop && cnt_q != '0) begin
      we    = 1'b1;
      waddr = tos_m1;
    end else if (do_push) begin
      // push+pop on an empty stack lands here too and behaves as a plain push
      we    = 1'b1;
      tos_d = tos_q + P_ONE;
      if (cnt_q == FULL) ovf_d = 1'b1;
      else               cnt_d = cnt_q + C_ONE;
    end else if (do_pop) begin
      if (cnt_q != '0) begin
        tos_d = tos_m1;
        cnt_d = cnt_q - C_ONE;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  bpred_ras_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (tos_m1),
    .rdata (top_addr)
  );

  assign top_valid = (cnt_q != '0);
  assign count     = cnt_q;
  assign snap_out  = {tos_q, cnt_q, top_addr};
  assign ovf_pulse = ovf_q;
  assign unf_pulse = unf_q;

`ifdef BPRED_RAS_STATS_EN
  logic [4:0][31:0] stat_q, stat_d;
  logic [4:0]       ev;

  assign ev = {restore, unf_d, ovf_d, do_pop, do_push};

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < 5; i++) stat_d[i] = stat_q[i] + {31'd0, ev[i]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stat_q <= '0;
    else          stat_q <= stat_d;
  end

  assign stat_push    = stat_q[0];
  assign stat_pop     = stat_q[1];
  assign stat_ovf     = stat_q[2];
  assign stat_unf     = stat_q[3];
  assign stat_restore = stat_q[4];
`endif
endmodule

// File: tb/tb_bpred_ras_ckpt.sv
// Self-checking bench for bpred_ras_ckpt: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based stack model.
module tb_bpred_ras_ckpt;
  localparam int DEPTH  = 16;
  localparam int AW     = 32;
  localparam int PTR_W  = 4;
  localparam int SNAP_W = PTR_W + PTR_W + 1 + AW;

  logic              clk, reset_n, stall, push, pop, restore;
  logic [AW-1:0]     push_addr, top_addr;
  logic              top_valid, ovf_pulse, unf_pulse;
  logic [PTR_W:0]    count;
  logic [SNAP_W-1:0] snap_out, snap_in;
`ifdef BPRED_RAS_STATS_EN
  logic [31:0] stat_push, stat_pop, stat_ovf, stat_unf, stat_restore;
`endif

  bpred_ras_ckpt #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .push      (push),
    .push_addr (push_addr),
    .pop       (pop),
    .top_addr  (top_addr),
    .top_valid (top_valid),
    .count     (count),
    .snap_out  (snap_out),
    .restore   (restore),
    .snap_in   (snap_in),
`ifdef BPRED_RAS_STATS_EN
    .stat_push    (stat_push),
    .stat_pop     (stat_pop),
    .stat_ovf     (stat_ovf),
    .stat_unf     (stat_unf),
    .stat_restore (stat_restore),
`endif
    .ovf_pulse (ovf_pulse),
    .unf_pulse (unf_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the edge and go idle.
  task automatic step(input bit p, input bit o, input bit s, input bit r,
                      input logic [AW-1:0] a, input logic [SNAP_W-1:0] sn);
    push = p; pop = o; stall = s; restore = r; push_addr = a; snap_in = sn;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; stall = 1'b0; restore = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit p, o, s;
    logic [AW-1:0] a;
    int ec;
    logic [AW-1:0] et;
    bit eo, eu;
  } vec_t;
  vec_t tv[$];

  task automatic addv(input bit p, o, s, input logic [AW-1:0] a, input int ec,
                      input logic [AW-1:0] et, input bit eo, eu);
    vec_t v;
    v.p = p; v.o = o; v.s = s; v.a = a; v.ec = ec; v.et = et; v.eo = eo; v.eu = eu;
    tv.push_back(v);
  endtask

  typedef struct { logic [AW-1:0] a; bit known; } ent_t;
  ent_t q[$], sq[$];

  logic [SNAP_W-1:0] sv;

  initial begin
    reset_n = 1'b0; stall = 0; push = 0; pop = 0; restore = 0;
    push_addr = '0; snap_in = '0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_top_valid", top_valid, 0);
    chk("rst_ovf", ovf_pulse, 0);
    chk("rst_unf", unf_pulse, 0);
`ifdef BPRED_RAS_STATS_EN
    chk("rst_stat_push", stat_push, 0);
`endif
    reset_n = 1'b1;

    // push A..D, pop back to empty, underflow, replace-top, stall
    addv(1,0,0,32'h100, 1,32'h100,0,0);
    addv(1,0,0,32'h104, 2,32'h104,0,0);
    addv(1,0,0,32'h108, 3,32'h108,0,0);
    addv(1,0,0,32'h10C, 4,32'h10C,0,0);
    addv(0,1,0,32'h0,   3,32'h108,0,0);
    addv(0,1,0,32'h0,   2,32'h104,0,0);
    addv(0,1,0,32'h0,   1,32'h100,0,0);
    addv(0,1,0,32'h0,   0,32'h0,  0,0);
    addv(0,1,0,32'h0,   0,32'h0,  0,1);
    addv(1,0,0,32'h200, 1,32'h200,0,0);
    addv(1,1,0,32'h300, 1,32'h300,0,0);
    addv(0,1,0,32'h0,   0,32'h0,  0,0);
    addv(1,1,0,32'h400, 1,32'h400,0,0);
    addv(1,0,1,32'h500, 1,32'h400,0,0);
    addv(0,1,1,32'h0,   1,32'h400,0,0);
    addv(0,1,0,32'h0,   0,32'h0,  0,0);
    foreach (tv[i]) begin
      step(tv[i].p, tv[i].o, tv[i].s, 1'b0, tv[i].a, '0);
      chk($sformatf("vec%0d_count", i), count, tv[i].ec);
      chk($sformatf("vec%0d_valid", i), top_valid, tv[i].ec != 0);
      if (tv[i].ec != 0) chk($sformatf("vec%0d_top", i), top_addr, tv[i].et);
      chk($sformatf("vec%0d_ovf", i), ovf_pulse, tv[i].eo);
      chk($sformatf("vec%0d_unf", i), unf_pulse, tv[i].eu);
    end

    // overflow by one, drain, underflow
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      step(1, 0, 0, 0, 32'h1000 + 32'(4 * i), '0);
      chk($sformatf("ovf_push%0d", i), ovf_pulse, i == DEPTH);
    end
    chk("ovf_count", count, DEPTH);
`ifdef BPRED_RAS_STATS_EN
    chk("stat_push17", stat_push, 17);
    chk("stat_ovf1", stat_ovf, 1);
`endif
    for (int k = 0; k < DEPTH; k++) begin
      chk($sformatf("drain_top%0d", k), top_addr, 32'h1040 - 32'(4 * k));
      step(0, 1, 0, 0, '0, '0);
    end
    chk("drain_count", count, 0);
    step(0, 1, 0, 0, '0, '0);
    chk("drain_unf", unf_pulse, 1);
`ifdef BPRED_RAS_STATS_EN
    chk("stat_unf1", stat_unf, 1);
`endif

    // snapshot, corrupt, restore; then restore under stall
    do_reset();
    step(1, 0, 0, 0, 32'h208, '0);
    step(1, 0, 0, 0, 32'h20C, '0);
    sv = snap_out;
    chk("snap_top", sv[AW-1:0], 32'h20C);
    chk("snap_count", sv[AW +: PTR_W+1], 2);
    chk("snap_tos", sv[AW+PTR_W+1 +: PTR_W], 2);
    step(0, 1, 0, 0, '0, '0);
    step(0, 1, 0, 0, '0, '0);
    step(1, 0, 0, 0, 32'h999, '0);
    chk("corrupt_top", top_addr, 32'h999);
    chk("corrupt_count", count, 1);
    step(1, 1, 0, 1, 32'h555, sv);
    chk("restore_count", count, 2);
    chk("restore_top", top_addr, 32'h20C);
    chk("restore_ovf", ovf_pulse, 0);
    step(1, 0, 1, 0, 32'hABC, '0);
    chk("stall_count", count, 2);
    chk("stall_top", top_addr, 32'h20C);
    step(0, 1, 0, 0, '0, '0);
    chk("pop_count", count, 1);
    step(0, 0, 1, 1, '0, sv);
    chk("stall_restore_count", count, 2);
    chk("stall_restore_top", top_addr, 32'h20C);

    // asynchronous reset in the middle of a push burst
    push = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_addr = 32'h7000 + 32'(i);
      @(posedge clk);
    end
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", top_valid, 0);
`ifdef BPRED_RAS_STATS_EN
    chk("async_rst_stat_push", stat_push, 0);
    chk("async_rst_stat_pop", stat_pop, 0);
    chk("async_rst_stat_restore", stat_restore, 0);
`endif
    push = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // randomized run against a queue model; entries below a restored top are unknown
    q.delete();
    for (int it = 0; it < 800; it++) begin
      bit p, o, s, r, eo, eu;
      logic [AW-1:0] a;
      int lim;
      lim = (it % 200 < 100) ? 3 : 1;
      p = ($urandom % 4) < lim;
      o = ($urandom % 4) >= lim;
      if ($urandom % 5 == 0) begin p = 1; o = 1; end
      s = ($urandom % 8 == 0);
      r = (sq.size() > 0 || sv[AW +: PTR_W+1] == 0) && ($urandom % 20 == 0);
      a = $urandom;
      if (it % 50 == 0) begin
        chk("rnd_snap_count", snap_out[AW +: PTR_W+1], q.size());
        if (q.size() > 0 && q[$].known) chk("rnd_snap_top", snap_out[AW-1:0], q[$].a);
      end
      if ($urandom % 10 == 0) begin
        sv = snap_out;
        sq = q;
      end
      eo = 0; eu = 0;
      if (r) begin
        q = sq;
        for (int j = 0; j + 1 < q.size(); j++) q[j].known = 0;
      end else if (!s) begin
        if (p && o) begin
          if (q.size() == 0) q.push_back('{a, 1'b1});
          else q[q.size()-1] = '{a, 1'b1};
        end else if (p) begin
          if (q.size() == DEPTH) begin void'(q.pop_front()); eo = 1; end
          q.push_back('{a, 1'b1});
        end else if (o) begin
          if (q.size() == 0) eu = 1;
          else void'(q.pop_back());
        end
      end
      step(p, o, s, r, a, sv);
      chk("rnd_count", count, q.size());
      chk("rnd_valid", top_valid, q.size() != 0);
      if (q.size() > 0 && q[$].known) chk("rnd_top", top_addr, q[$].a);
      chk("rnd_ovf", ovf_pulse, eo);
      chk("rnd_unf", unf_pulse, eu);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
